// File: rtl/riscv_core.sv
// Minimal multi-cycle RV32I core: one FETCH clock, one EXEC clock per instruction,
// sharing a single combinational-read byte-addressed memory port.
module riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        ce,
  output logic [31:0] a,
  input  logic [31:0] i,
  output logic [31:0] o,
  output logic        w,
  output logic [1:0]  ws
);

  typedef enum logic {FETCH, EXEC} state_e;

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] rf_q [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1_a, rs2_a;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_d, rd_val_d, ea;
  logic        rd_we_d, is_load, is_store, exec;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] xs, ys;
    xs = x;
    ys = y;
    case (fn)
      3'd0:    alu = alt ? x - y : x + y;
      3'd1:    alu = x << y[4:0];
      3'd2:    alu = {31'b0, xs < ys};
      3'd3:    alu = {31'b0, x < y};
      3'd4:    alu = x ^ y;
      3'd5:    alu = alt ? 32'(xs >>> y[4:0]) : x >> y[4:0];
      3'd6:    alu = x | y;
      default: alu = x & y;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] fn, input logic [31:0] x,
                                    input logic [31:0] y);
    logic signed [31:0] xs, ys;
    xs = x;
    ys = y;
    case (fn)
      3'd0:    br_taken = (x == y);
      3'd1:    br_taken = (x != y);
      3'd4:    br_taken = (xs < ys);
      3'd5:    br_taken = (xs >= ys);
      3'd6:    br_taken = (x < y);
      3'd7:    br_taken = (x >= y);
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] fn, input logic [31:0] d);
    case (fn)
      3'd0:    ld_ext = {{24{d[7]}}, d[7:0]};
      3'd1:    ld_ext = {{16{d[15]}}, d[15:0]};
      3'd4:    ld_ext = {24'b0, d[7:0]};
      3'd5:    ld_ext = {16'b0, d[15:0]};
      default: ld_ext = d;
    endcase
  endfunction

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1_a  = ir_q[19:15];
  assign rs2_a  = ir_q[24:20];
  assign rs1    = (rs1_a == 5'd0) ? 32'd0 : rf_q[rs1_a];
  assign rs2    = (rs2_a == 5'd0) ? 32'd0 : rf_q[rs2_a];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Decode/execute; anything unrecognised falls through as a NOP (pc+4, no write).
  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we_d  = 1'b0;
    rd_val_d = 32'd0;
    is_load  = 1'b0;
    is_store = 1'b0;
    ea       = rs1 + imm_i;
    case (opcode)
      OP_LUI:   begin rd_we_d = 1'b1; rd_val_d = imm_u; end
      OP_AUIPC: begin rd_we_d = 1'b1; rd_val_d = pc_q + imm_u; end
      OP_JAL:   begin rd_we_d = 1'b1; rd_val_d = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR:  begin
        rd_we_d  = 1'b1;
        rd_val_d = pc_q + 32'd4;
        pc_d     = (rs1 + imm_i) & ~32'd1;
      end
      OP_BR:    if (br_taken(f3, rs1, rs2)) pc_d = pc_q + imm_b;
      OP_LOAD:  if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
        is_load  = 1'b1;
        rd_we_d  = 1'b1;
        rd_val_d = ld_ext(f3, i);
      end
      OP_STORE: if (f3 < 3'd3) begin
        is_store = 1'b1;
        ea       = rs1 + imm_s;
      end
      OP_IMM:   begin rd_we_d = 1'b1; rd_val_d = alu(f3, f3 == 3'd5 && ir_q[30], rs1, imm_i); end
      OP_REG:   begin rd_we_d = 1'b1; rd_val_d = alu(f3, ir_q[30], rs1, rs2); end
      default:  ;
    endcase
  end

  assign exec = (state_q == EXEC);
  assign a    = (exec && (is_load || is_store)) ? ea : pc_q;
  assign w    = exec && is_store && ce;
  assign ws   = (exec && is_store) ? f3[1:0] : 2'b00;
  assign o    = (exec && is_store) ? rs2 : 32'd0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      for (int k = 0; k < 32; k++) rf_q[k] <= 32'd0;
    end else if (ce) begin
      case (state_q)
        FETCH: begin
          ir_q    <= i;
          state_q <= EXEC;
        end
        default: begin
          pc_q    <= pc_d;
          state_q <= FETCH;
          if (rd_we_d && rd != 5'd0) rf_q[rd] <= rd_val_d;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: a small program runs against a byte memory model;
// stores are checked against a scoreboard, fetch/freeze behaviour checked inline.
module tb_riscv_core;

  logic        clock;
  logic        rst_n;
  logic        ce;
  logic [31:0] a, i, o;
  logic        w;
  logic [1:0]  ws;

  logic [7:0]  mem [0:8191];
  int          n_checks;
  int          n_fails;

  typedef struct {
    logic [31:0] a;
    logic [31:0] o;
    logic [1:0]  ws;
  } st_t;
  st_t sb[$];

  riscv_core #(.RESET_PC(32'h0)) dut (
    .clock(clock), .rst_n(rst_n), .ce(ce),
    .a(a), .i(i), .o(o), .w(w), .ws(ws)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [12:0] a0, a1, a2, a3;
  assign a0 = a[12:0];
  assign a1 = a0 + 13'd1;
  assign a2 = a0 + 13'd2;
  assign a3 = a0 + 13'd3;
  assign i  = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clock) begin
    if (w === 1'b1) begin
      mem[a0] = o[7:0];
      if (ws != 2'b00) mem[a1] = o[15:8];
      if (ws == 2'b10) begin
        mem[a2] = o[23:16];
        mem[a3] = o[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n === 1'b1 && w === 1'b1) begin
      st_t e;
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{a: 32'hDEAD_BEEF, o: 32'hDEAD_BEEF, ws: 2'b11};
      check("store_a", a, e.a);
      check("store_o", o, e.o);
      check("store_ws", {30'b0, ws}, {30'b0, e.ws});
    end
  end

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic put(input int addr, input logic [31:0] insn);
    mem[addr]   = insn[7:0];
    mem[addr+1] = insn[15:8];
    mem[addr+2] = insn[23:16];
    mem[addr+3] = insn[31:24];
  endtask

  task automatic expect_st(input logic [31:0] ea, input logic [31:0] eo, input logic [1:0] ews);
    sb.push_back('{a: ea, o: eo, ws: ews});
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    ce    = 1'b1;
    for (int k = 0; k < 8192; k++) mem[k] = 8'h00;

    put(32'h00, ei(12'd5,   5'd0, 3'd0, 5'd1, 7'h13));     // ADDI x1,x0,5
    put(32'h04, ei(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13));     // ADDI x2,x1,-7
    put(32'h08, er(7'd0, 5'd2, 5'd1, 3'd3, 5'd3));         // SLTU x3,x1,x2
    put(32'h0C, er(7'd0, 5'd2, 5'd1, 3'd2, 5'd4));         // SLT  x4,x1,x2
    put(32'h10, es(12'h100, 5'd2, 5'd0, 3'd2));            // SW x2,0x100
    put(32'h14, ei(12'h100, 5'd0, 3'd0, 5'd5, 7'h03));     // LB
    put(32'h18, ei(12'h100, 5'd0, 3'd4, 5'd6, 7'h03));     // LBU
    put(32'h1C, ei(12'h100, 5'd0, 3'd1, 5'd7, 7'h03));     // LH
    put(32'h20, ei(12'h100, 5'd0, 3'd5, 5'd8, 7'h03));     // LHU
    put(32'h24, es(12'h101, 5'd1, 5'd0, 3'd0));            // SB x1,0x101
    put(32'h28, ei(12'h100, 5'd0, 3'd2, 5'd9, 7'h03));     // LW x9,0x100
    for (int k = 0; k < 7; k++)
      put(32'h2C + 4*k, es(12'h200 + 12'(4*k), 5'(3+k), 5'd0, 3'd2));
    put(32'h48, eb(13'd8, 5'd0, 5'd1, 3'd1));              // BNE x1,x0,+8
    put(32'h4C, ei(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));      // skipped
    put(32'h50, eb(13'd8, 5'd0, 5'd1, 3'd0));              // BEQ not taken
    put(32'h54, ej(21'd12, 5'd0));                         // JAL x0,+12
    put(32'h58, es(12'h220, 5'd12, 5'd0, 3'd2));           // SW x12,0x220
    put(32'h5C, ei(12'd0, 5'd12, 3'd0, 5'd0, 7'h67));      // JALR x0,0(x12)
    put(32'h60, ej(21'h1FFFF8, 5'd12));                    // JAL x12,-8
    put(32'h64, es(12'h224, 5'd10, 5'd0, 3'd2));           // SW x10,0x224
    put(32'h68, es(12'h300, 5'd1, 5'd0, 3'd2));            // SW x1,0x300
    put(32'h6C, ei(12'h078, 5'd0, 3'd0, 5'd13, 7'h13));    // ADDI x13,x0,0x78
    put(32'h70, ei(12'd1, 5'd13, 3'd0, 5'd13, 7'h67));     // JALR x13,1(x13)
    put(32'h74, ei(12'd1, 5'd0, 3'd0, 5'd10, 7'h13));      // skipped
    put(32'h78, es(12'h228, 5'd13, 5'd0, 3'd2));           // SW x13,0x228
    put(32'h7C, ei(12'h401, 5'd2, 3'd5, 5'd14, 7'h13));    // SRAI x14,x2,1
    put(32'h80, es(12'h22C, 5'd14, 5'd0, 3'd2));           // SW x14,0x22C
    put(32'h84, ej(21'd0, 5'd0));                          // JAL x0,0

    expect_st(32'h100, 32'hFFFF_FFFE, 2'b10);
    expect_st(32'h101, 32'h0000_0005, 2'b00);
    expect_st(32'h200, 32'h0000_0001, 2'b10);
    expect_st(32'h204, 32'h0000_0000, 2'b10);
    expect_st(32'h208, 32'hFFFF_FFFE, 2'b10);
    expect_st(32'h20C, 32'h0000_00FE, 2'b10);
    expect_st(32'h210, 32'hFFFF_FFFE, 2'b10);
    expect_st(32'h214, 32'h0000_FFFE, 2'b10);
    expect_st(32'h218, 32'hFFFF_05FE, 2'b10);
    expect_st(32'h220, 32'h0000_0064, 2'b10);
    expect_st(32'h224, 32'h0000_0000, 2'b10);
    expect_st(32'h300, 32'h0000_0005, 2'b10);
    expect_st(32'h228, 32'h0000_0074, 2'b10);
    expect_st(32'h22C, 32'hFFFF_FFFF, 2'b10);

    #2;
    check("rst_a", a, 32'h0);
    check("rst_w", {31'b0, w}, 32'h0);
    check("rst_o", o, 32'h0);
    check("rst_ws", {30'b0, ws}, 32'h0);
    cyc();
    cyc();
    check("rst_hold_a", a, 32'h0);
    rst_n = 1'b1;
    check("fetch0_a", a, 32'h0);
    cyc();
    check("exec0_w", {31'b0, w}, 32'h0);
    cyc();
    check("fetch1_a", a, 32'h4);

    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (w === 1'b1 && a === 32'h300) found = 1'b1;
      else cyc();
    end
    check("ce_store_reached", {31'b0, found}, 32'h1);

    ce = 1'b0;
    #1;
    check("ce0_w", {31'b0, w}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("ce0_hold_w", {31'b0, w}, 32'h0);
      check("ce0_hold_a", a, 32'h300);
    end
    ce = 1'b1;
    #1;
    check("ce1_w", {31'b0, w}, 32'h1);
    cyc();
    check("resume_fetch_a", a, 32'h6C);

    for (int k = 0; k < 200 && sb.size() != 0; k++) cyc();
    repeat (4) cyc();
    check("sb_drained", sb.size(), 32'd0);

    check("mem_100", {24'b0, mem[13'h100]}, 32'hFE);
    check("mem_101", {24'b0, mem[13'h101]}, 32'h05);
    check("mem_102", {24'b0, mem[13'h102]}, 32'hFF);
    check("mem_300", {24'b0, mem[13'h300]}, 32'h05);

    rst_n = 1'b0;
    #1;
    check("midrst_a", a, 32'h0);
    check("midrst_w", {31'b0, w}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
